// File: rtl/md_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : md_scheduler                                               |
// | Description : Sequences one MULT/MULTU/DIV/DIVU at a time onto an        |
// |               external fixed-latency multiplier and an external          |
// |               iterative divider. It returns the {HI,LO} result as a      |
// |               one-cycle completion pulse and stalls decode while an      |
// |               operation is in flight.                                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset          clock, synchronous active-high reset               |
// |   de_mult_en/div_en   multiply / divide decoded this cycle               |
// |   de_is_signed        signed operation                                   |
// |   de_MD_src1/src2     rs / rt operands                                   |
// |   de_hilo_access      MFHI/MFLO/MTHI/MTLO decoded this cycle             |
// |   flush               decode instruction squashed this cycle             |
// |   mul_*               multiplier launch, operands and result             |
// |   div_*               divider launch, operands, done and result          |
// |   md_busy, md_stall   scheduler occupied / decode must hold              |
// |   wb_MD_complete/res  completion pulse and {HI,LO} result                |
// +--------------------------------------------------------------------------+
module md_scheduler #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_mult_en,
  input  logic        de_div_en,
  input  logic        de_is_signed,
  input  logic [31:0] de_MD_src1,
  input  logic [31:0] de_MD_src2,
  input  logic        de_hilo_access,
  input  logic        flush,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        md_busy,
  output logic        md_stall,
  output logic        wb_MD_complete,
  output logic [63:0] wb_MD_result
);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_mul_wait = 2'd1;
  localparam logic [1:0] c_div_wait = 2'd2;
  localparam logic [1:0] c_done     = 2'd3;

  localparam logic [3:0] c_mul_lat  = 4'(MUL_LAT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [3:0]  r_cnt;
  logic        r_div_issued;
  logic        r_signed;
  logic [31:0] r_src_a;
  logic [31:0] r_src_b;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_div_by_zero;

  // Flush only blocks a new accept; anything already in flight belongs to an
  // older instruction and runs to completion.
  assign w_accept      = (r_state == c_idle) & (de_mult_en | de_div_en) & ~flush;
  assign w_div_by_zero = (de_MD_src2 == 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; mult wins when both enables are high.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_accept) begin
          if (de_mult_en) begin
            w_state_next = c_mul_wait;
          end else if (w_div_by_zero) begin
            w_state_next = c_done;
          end else begin
            w_state_next = c_div_wait;
          end
        end
      end
      c_mul_wait: begin
        if (r_cnt == c_mul_lat) begin
          w_state_next = c_done;
        end
      end
      c_div_wait: begin
        if (div_done) begin
          w_state_next = c_done;
        end
      end
      default: begin
        w_state_next = c_idle;
      end
    endcase
  end

  // Operand, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_div_issued <= 1'b0;
      r_signed     <= 1'b0;
      r_src_a      <= 32'd0;
      r_src_b      <= 32'd0;
      r_result     <= 64'd0;
    end else begin
      if (w_accept) begin
        r_signed     <= de_is_signed;
        r_src_a      <= de_MD_src1;
        r_src_b      <= de_MD_src2;
        r_cnt        <= 4'd0;
        r_div_issued <= 1'b0;
        // Divide by zero never reaches the divider: HI keeps the dividend,
        // LO is all ones.
        if (!de_mult_en && w_div_by_zero) begin
          r_result <= {de_MD_src1, 32'hFFFF_FFFF};
        end
      end
      case (r_state)
        c_mul_wait: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == c_mul_lat) begin
            r_result <= mul_result;
          end
        end
        c_div_wait: begin
          r_div_issued <= 1'b1;
          if (div_done) begin
            r_result <= {div_result[63:32], div_result[31:0]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; md_stall is the only output with an input path.
  always_comb begin
    mul_start      = (r_state == c_mul_wait) & (r_cnt == 4'd0);
    div_start      = (r_state == c_div_wait) & ~r_div_issued;
    md_busy        = (r_state != c_idle);
    wb_MD_complete = (r_state == c_done);
    // DONE is covered too so a HI/LO access cannot race the completion write.
    md_stall       = (de_mult_en | de_div_en | de_hilo_access) &
                     (r_state != c_idle) & ~reset;
  end

  assign mul_signed   = r_signed;
  assign mul_a        = r_src_a;
  assign mul_b        = r_src_b;
  assign div_signed   = r_signed;
  assign div_a        = r_src_a;
  assign div_b        = r_src_b;
  assign wb_MD_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_md_scheduler                                            |
// | Description : Directed self-checking bench for md_scheduler with a       |
// |               fixed-latency multiplier model and a 33-cycle divider.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_md_scheduler;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_mult_en, de_div_en, de_is_signed, de_hilo_access, flush;
  logic [31:0] de_MD_src1, de_MD_src2;
  logic        mul_start, mul_signed, div_start, div_signed;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_result, div_result;
  logic        div_done;
  logic        md_busy, md_stall, wb_MD_complete;
  logic [63:0] wb_MD_result;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  md_scheduler #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .de_mult_en(de_mult_en), .de_div_en(de_div_en), .de_is_signed(de_is_signed),
    .de_MD_src1(de_MD_src1), .de_MD_src2(de_MD_src2),
    .de_hilo_access(de_hilo_access), .flush(flush),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result),
    .md_busy(md_busy), .md_stall(md_stall),
    .wb_MD_complete(wb_MD_complete), .wb_MD_result(wb_MD_result)
  );

  // Multiplier model: result valid MUL_LAT cycles after mul_start, junk otherwise.
  logic [63:0] prod;
  logic [63:0] mpipe [MUL_LAT];
  always_comb begin
    if (mul_signed)
      prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else
      prod = {32'd0, mul_a} * {32'd0, mul_b};
  end
  always @(posedge clk) begin
    mpipe[0] <= mul_start ? prod : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  // Divider model: div_done 33 cycles after div_start; force_done injects a stray pulse.
  function automatic logic [63:0] divf(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return '1;
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  int          dcnt = 0;
  logic [63:0] dres = '0;
  logic        force_done = 1'b0;
  int          n_div_start = 0;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt        <= 33;
      dres        <= divf(div_signed, div_a, div_b);
      n_div_start <= n_div_start + 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done   = (dcnt == 1) | force_done;
  assign div_result = div_done ? dres : 64'hDEAD_DEAD_DEAD_DEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int starts0;
    int cyc;
    int n_cmp;
    logic prev_done;
    logic seen;

    reset = 1'b1; de_mult_en = 0; de_div_en = 0; de_is_signed = 0;
    de_hilo_access = 0; flush = 0; de_MD_src1 = 0; de_MD_src2 = 0;
    for (int i = 0; i < MUL_LAT; i++) mpipe[i] = 64'hBAD0_BAD0_BAD0_BAD0;
    tick(); tick();
    check("reset_busy", 64'(md_busy), 64'd0);
    check("reset_stall", 64'(md_stall), 64'd0);
    check("reset_complete", 64'(wb_MD_complete), 64'd0);
    check("reset_result", wb_MD_result, 64'd0);
    check("reset_operands", {mul_a, mul_b}, 64'd0);
    check("reset_starts", {62'd0, mul_start, div_start}, 64'd0);
    reset = 1'b0;
    tick();

    // Signed MULT -3 x 5
    de_mult_en = 1; de_is_signed = 1; de_MD_src1 = 32'hFFFF_FFFD; de_MD_src2 = 32'd5;
    #1;
    check("mult_accept_no_stall", 64'(md_stall), 64'd0);
    tick();                                             // T+1
    de_mult_en = 0;
    check("mult_start_t1", 64'(mul_start), 64'd1);
    check("mult_signed", 64'(mul_signed), 64'd1);
    check("mult_operands", {mul_a, mul_b}, {32'hFFFF_FFFD, 32'd5});
    check("mult_busy", 64'(md_busy), 64'd1);
    tick();                                             // T+2
    check("mult_start_pulse", 64'(mul_start), 64'd0);
    tick();                                             // T+3
    check("mult_no_early_complete", 64'(wb_MD_complete), 64'd0);
    tick();                                             // T+4
    check("mult_complete_t4", 64'(wb_MD_complete), 64'd1);
    check("mult_result", wb_MD_result, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    check("mult_complete_one_cycle", 64'(wb_MD_complete), 64'd0);
    check("mult_idle_after", 64'(md_busy), 64'd0);

    // MULTU FFFFFFFF x FFFFFFFF, request held to exercise the hazard
    de_mult_en = 1; de_is_signed = 0; de_MD_src1 = 32'hFFFF_FFFF; de_MD_src2 = 32'hFFFF_FFFF;
    tick();                                             // T+1
    check("multu_signed", 64'(mul_signed), 64'd0);
    check("held_mult_stall_t1", 64'(md_stall), 64'd1);
    tick(); tick();                                     // T+3
    check("held_mult_stall_t3", 64'(md_stall), 64'd1);
    tick();                                             // T+4 DONE
    check("held_mult_stall_done", 64'(md_stall), 64'd1);
    check("multu_complete", 64'(wb_MD_complete), 64'd1);
    check("multu_result", wb_MD_result, 64'hFFFF_FFFE_0000_0001);
    tick();                                             // IDLE, held request accepted here
    check("held_mult_stall_drop", 64'(md_stall), 64'd0);
    tick();
    de_mult_en = 0;
    check("second_mult_started", 64'(mul_start), 64'd1);
    de_hilo_access = 1;
    #1;
    check("mfhi_stall_mul_wait", 64'(md_stall), 64'd1);
    de_hilo_access = 0;
    tick(); tick(); tick();
    check("second_mult_complete", {63'd0, wb_MD_complete}, 64'd1);
    check("second_mult_result", wb_MD_result, 64'hFFFF_FFFE_0000_0001);
    tick();
    de_hilo_access = 1;
    #1;
    check("mfhi_idle_no_stall", 64'(md_stall), 64'd0);
    de_hilo_access = 0;

    // Signed DIV 7 / -2
    starts0 = n_div_start;
    de_div_en = 1; de_is_signed = 1; de_MD_src1 = 32'd7; de_MD_src2 = 32'hFFFF_FFFE;
    tick();                                             // T+1
    de_div_en = 0;
    check("div_start_t1", 64'(div_start), 64'd1);
    check("div_signed", 64'(div_signed), 64'd1);
    cyc = 0; prev_done = 0; seen = 0;
    while (cyc < 60 && !seen) begin
      prev_done = div_done;
      tick();
      cyc++;
      seen = wb_MD_complete;
    end
    check("div_complete_seen", 64'(seen), 64'd1);
    check("div_complete_latency", 64'(cyc), 64'd34);
    check("div_complete_after_done", 64'(prev_done), 64'd1);
    check("div_result", wb_MD_result, {32'h1, 32'hFFFF_FFFD});
    check("div_start_once", 64'(n_div_start - starts0), 64'd1);
    tick();

    // DIVU by zero
    starts0 = n_div_start;
    de_div_en = 1; de_is_signed = 0; de_MD_src1 = 32'h1234_5678; de_MD_src2 = 32'd0;
    tick();                                             // T+1
    de_div_en = 0;
    check("divz_complete_t1", 64'(wb_MD_complete), 64'd1);
    check("divz_result", wb_MD_result, {32'h1234_5678, 32'hFFFF_FFFF});
    tick();
    check("divz_no_div_start", 64'(n_div_start - starts0), 64'd0);
    check("divz_idle", 64'(md_busy), 64'd0);

    // Flushed divide is not accepted
    starts0 = n_div_start;
    de_div_en = 1; flush = 1; de_MD_src1 = 32'd9; de_MD_src2 = 32'd3;
    tick();
    de_div_en = 0; flush = 0;
    check("flush_no_accept", 64'(md_busy), 64'd0);
    tick();
    check("flush_no_div_start", 64'(n_div_start - starts0), 64'd0);

    // Reset in the middle of DIV_WAIT
    de_div_en = 1; de_is_signed = 0; de_MD_src1 = 32'd100; de_MD_src2 = 32'd7;
    tick();
    de_div_en = 0;
    check("rst_div_started", 64'(div_start), 64'd1);
    tick(); tick(); tick();
    check("rst_div_busy", 64'(md_busy), 64'd1);
    reset = 1; de_hilo_access = 1;
    #1;
    check("stall_low_in_reset", 64'(md_stall), 64'd0);
    tick();
    reset = 0; de_hilo_access = 0;
    check("rst_to_idle", 64'(md_busy), 64'd0);
    force_done = 1;
    tick();
    force_done = 0;
    n_cmp = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_MD_complete) n_cmp++;
      tick();
    end
    check("rst_no_completion", 64'(n_cmp), 64'd0);
    check("rst_still_idle", 64'(md_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_scheduler.md
# md_scheduler

Controller that sequences the shared multiply/divide resources for the decode stage. It accepts one MULT/MULTU/DIV/DIVU operation at a time and drives an external fixed-latency multiplier and an external iterative divider. It returns the 64-bit {HI,LO} result to the decode-stage HI/LO registers as a one-cycle completion pulse. It stalls decode while an operation is in flight.

## Interface
- MUL_LAT, 2: multiplier latency in cycles, from the `mul_start` cycle to the cycle `mul_result` is valid (1..15).
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- de_mult_en  in  1  MULT/MULTU decoded this cycle.
- de_div_en  in  1  DIV/DIVU decoded this cycle.
- de_is_signed  in  1  signed operation.
- de_MD_src1  in  32  rs operand (dividend / multiplicand).
- de_MD_src2  in  32  rt operand (divisor / multiplier).
- de_hilo_access  in  1  MFHI/MFLO/MTHI/MTLO decoded this cycle.
- flush  in  1  decode instruction is being squashed (exception/ERET) this cycle.
- mul_start  out  1  multiplier launch pulse.
- mul_signed  out  1  signed multiply.
- mul_a, mul_b  out  32  latched operands.
- mul_result  in  64  {hi,lo}; valid exactly MUL_LAT cycles after `mul_start`.
- div_start  out  1  divider launch pulse.
- div_signed  out  1  signed divide.
- div_a, div_b  out  32  latched operands.
- div_done  in  1  divider result valid (single-cycle pulse).
- div_result  in  64  {remainder,quotient}.
- md_busy  out  1  state != IDLE.
- md_stall  out  1  decode must hold.
- wb_MD_complete  out  1  result pulse.
- wb_MD_result  out  64  {HI,LO}.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Accept condition: state == IDLE & (de_mult_en | de_div_en) & ~flush.
  - On accept, latch signed flag and both operands into the operand registers.
  - If both enables are high, mult wins.
- IDLE transitions:
  - mult accepted -> MUL_WAIT, counter cleared to 0.
  - div accepted with de_MD_src2 == 0 -> DONE directly. Result is {de_MD_src1, 32'hFFFF_FFFF}. The divider is never started.
  - div accepted with nonzero divisor -> DIV_WAIT.
- MUL_WAIT:
  - `mul_start` = 1 when counter == 0.
  - Counter increments every cycle.
  - When counter == MUL_LAT, latch `mul_result` and go to DONE.
- DIV_WAIT:
  - `div_start` = 1 in the first DIV_WAIT cycle only.
  - On `div_done`, latch {div_result[63:32], div_result[31:0]} as {HI,LO} and go to DONE.
  - `div_done` outside DIV_WAIT is ignored.
- DONE: `wb_MD_complete` = 1 and `wb_MD_result` = latched result, for exactly one cycle; then IDLE.
- md_stall = (de_mult_en | de_div_en | de_hilo_access) & (state != IDLE). This is combinational.
  - DONE is included, so a HI/LO access never races the completion write.
  - The accept cycle itself does not stall.
- flush only blocks accept in that cycle. In-flight operations belong to older instructions and always complete.
- mul_signed/div_signed, mul_a/div_a and mul_b/div_b are driven from the same operand registers.

## Timing
- Reset values: state IDLE, counter 0, operand/result registers 0, all outputs 0. `md_stall` is 0 while reset is high.
- Reset during MUL_WAIT or DIV_WAIT returns to IDLE next cycle with no completion. A later `div_done` or `mul_result` is ignored.
- Multiply, accepted in cycle T:
  - `mul_start` at T+1.
  - `mul_result` sampled at T+1+MUL_LAT.
  - `wb_MD_complete` at T+2+MUL_LAT (T+4 for the default).
- Divide: `div_start` at T+1. If `div_done` arrives at cycle D, `wb_MD_complete` is at D+1.
- Divide by zero: `wb_MD_complete` at T+1.
- Next accept is possible no earlier than the cycle after DONE.
- A held request is accepted in the cycle after DONE; stall drops in that same cycle.
- All outputs except `md_stall` come from registers or decoded state, with no input-to-output paths.

## Test plan
- Signed MULT: -3 × 5 (src1=32'hFFFF_FFFD, src2=5), MUL_LAT=2, accept at T.
  - `mul_start` at T+1.
  - `wb_MD_complete` at T+4 with 64'hFFFF_FFFF_FFFF_FFF1.
- MULTU: 32'hFFFF_FFFF × 32'hFFFF_FFFF -> result 64'hFFFF_FFFE_0000_0001; `mul_signed` = 0.
- DIV: 7 / -2 (signed), divider model `div_done` 33 cycles after `div_start`.
  - Completion one cycle after `div_done` with {HI,LO} = {32'h1, 32'hFFFF_FFFD}.
  - `div_start` pulses exactly once.
- DIVU by zero: src1 = 32'h1234_5678.
  - `wb_MD_complete` at T+1 with {32'h1234_5678, 32'hFFFF_FFFF}.
  - `div_start` never asserts.
- Hazard while a MULT is in flight:
  - Hold a second MULT -> `md_stall` = 1 through the DONE cycle, then the second MULT is accepted the cycle after DONE.
  - MFHI during MUL_WAIT -> `md_stall` = 1.
  - MFHI in IDLE -> `md_stall` = 0.
- Flush, then reset:
  - `de_div_en` with `flush` = 1 -> no accept and no `div_start`.
  - Reset asserted mid DIV_WAIT -> IDLE.
  - A subsequent `div_done` produces no `wb_MD_complete`.
